// File: rtl/axis_egress.sv
// Egress skid stage: internal AXI stream to external AXI stream, plus per-link frame statistics.
// Latency: 1 cycle from input accept to m_* valid; full throughput when the sink keeps m_tready high.
// Backpressure: s_tready is a flop (!skid valid); one extra beat is absorbed in SKID when the sink stalls.
module axis_egress #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [USER_WIDTH-1:0] s_tuser,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic [CNT_WIDTH-1:0]  stat_pkt_count,
  output logic [CNT_WIDTH-1:0]  stat_err_count,
  output logic [CNT_WIDTH-1:0]  stat_beat_count,
  output logic                  in_frame
);

  // Output register (OUT)
  logic                  out_vld_q,  out_vld_d;
  logic [DATA_WIDTH-1:0] out_dat_q,  out_dat_d;
  logic                  out_last_q, out_last_d;
  logic [USER_WIDTH-1:0] out_user_q, out_user_d;

  // Skid register (SKID)
  logic                  skid_vld_q,  skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_dat_q,  skid_dat_d;
  logic                  skid_last_q, skid_last_d;
  logic [USER_WIDTH-1:0] skid_user_q, skid_user_d;

  // Registered upstream ready
  logic                  s_rdy_q, s_rdy_d;

  // Statistics
  logic [CNT_WIDTH-1:0]  pkt_cnt_q,  pkt_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q,  err_cnt_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  in_frame_q, in_frame_d;

  logic in_hs;
  logic out_hs;

  assign in_hs  = s_tvalid && s_rdy_q;
  assign out_hs = out_vld_q && m_tready;

  // Steer accepted beats into OUT or SKID and refill OUT from SKID as the sink drains.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_dat_d   = out_dat_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    skid_vld_d  = skid_vld_q;
    skid_dat_d  = skid_dat_q;
    skid_last_d = skid_last_q;
    skid_user_d = skid_user_q;

    if (out_hs) begin
      if (skid_vld_q) begin
        // SKID is older than anything upstream; no input is accepted while it is full.
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        out_last_d = skid_last_q;
        out_user_d = skid_user_q;
        skid_vld_d = 1'b0;
      end else if (in_hs) begin
        out_vld_d  = 1'b1;
        out_dat_d  = s_tdata;
        out_last_d = s_tlast;
        out_user_d = s_tuser;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (!out_vld_q) begin
      // OUT empty implies SKID empty, so the beat goes straight to OUT.
      if (in_hs) begin
        out_vld_d  = 1'b1;
        out_dat_d  = s_tdata;
        out_last_d = s_tlast;
        out_user_d = s_tuser;
      end
    end else if (in_hs) begin
      // OUT stalled: park the beat that was already promised by s_tready.
      skid_vld_d  = 1'b1;
      skid_dat_d  = s_tdata;
      skid_last_d = s_tlast;
      skid_user_d = s_tuser;
    end

    s_rdy_d = !skid_vld_d;
  end

  // Count external beats, frames and errored frames; track position within a frame.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    beat_cnt_d = beat_cnt_q;
    in_frame_d = in_frame_q;
    if (out_hs) begin
      beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
      in_frame_d = !out_last_q;
      if (out_last_q) begin
        pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
        if (out_user_q[0]) begin
          err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  // State registers; reset discards any beats in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_dat_q  <= '0;
      skid_last_q <= 1'b0;
      skid_user_q <= '0;
      s_rdy_q     <= 1'b0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      in_frame_q  <= 1'b0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
      skid_vld_q  <= skid_vld_d;
      skid_dat_q  <= skid_dat_d;
      skid_last_q <= skid_last_d;
      skid_user_q <= skid_user_d;
      s_rdy_q     <= s_rdy_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      in_frame_q  <= in_frame_d;
    end
  end

  assign s_tready        = s_rdy_q;
  assign m_tvalid        = out_vld_q;
  assign m_tdata         = out_dat_q;
  assign m_tlast         = out_last_q;
  assign m_tuser         = out_user_q;
  assign stat_pkt_count  = pkt_cnt_q;
  assign stat_err_count  = err_cnt_q;
  assign stat_beat_count = beat_cnt_q;
  assign in_frame        = in_frame_q;

endmodule

// File: tb/tb_axis_egress.sv
module tb_axis_egress;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic [0:0]    s_tuser;
  logic          m_tready;

  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic [0:0]    m_tuser;
  logic [31:0]   stat_pkt_count, stat_err_count, stat_beat_count;
  logic          in_frame;

  logic          s4_tready;
  logic [DW-1:0] m4_tdata;
  logic          m4_tvalid;
  logic          m4_tlast;
  logic [0:0]    m4_tuser;
  logic [3:0]    s4_pkt, s4_err, s4_beat;
  logic          in_frame4;

  int tot = 0;
  int bad = 0;

  logic [DW+1:0] obs_q[$];

  always #5 clk = ~clk;

  axis_egress #(.DATA_WIDTH(DW), .USER_WIDTH(1), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .stat_pkt_count(stat_pkt_count), .stat_err_count(stat_err_count),
    .stat_beat_count(stat_beat_count), .in_frame(in_frame)
  );

  axis_egress #(.DATA_WIDTH(DW), .USER_WIDTH(1), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s4_tready), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tdata(m4_tdata), .m_tvalid(m4_tvalid), .m_tready(m_tready), .m_tlast(m4_tlast), .m_tuser(m4_tuser),
    .stat_pkt_count(s4_pkt), .stat_err_count(s4_err),
    .stat_beat_count(s4_beat), .in_frame(in_frame4)
  );

  // Record every external handshake in order.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) obs_q.push_back({m_tuser, m_tlast, m_tdata});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", tot, bad);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = '0; m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    obs_q.delete();
  endtask

  // Present one beat, hold until accepted, then idle the input.
  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic u, output bit ok);
    bit acc;
    ok = 1'b0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l; s_tuser = u;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); acc = s_tready;
      @(posedge clk); #1;
      if (acc) begin ok = 1'b1; break; end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = '0; m_tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tot++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_s_tready got=%b exp=0", s_tready); end
    tot++; if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tlast !== 1'b0) begin
      bad++; $display("FAIL reset_m got vld=%b dat=%h last=%b exp 0", m_tvalid, m_tdata, m_tlast); end
    tot++; if (stat_pkt_count !== 0 || stat_err_count !== 0 || stat_beat_count !== 0 || in_frame !== 1'b0) begin
      bad++; $display("FAIL reset_stats got pkt=%0d err=%0d beat=%0d inf=%b exp 0", stat_pkt_count, stat_err_count, stat_beat_count, in_frame); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    tot++; if (s_tready !== 1'b0) begin bad++; $display("FAIL release_no_edge_s_tready got=%b exp=0", s_tready); end
    @(negedge clk);
    tot++; if (s_tready !== 1'b1) begin bad++; $display("FAIL release_one_edge_s_tready got=%b exp=1", s_tready); end
    tot++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL release_m_tvalid got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    apply_reset();
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 64'h0; s_tlast = 1'b0; s_tuser = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 7) begin s_tdata = 64'(i + 1); s_tlast = (i + 1 == 7); end
      else s_tvalid = 1'b0;
      @(negedge clk);
      if (m_tvalid !== 1'b1 || m_tdata !== 64'(i) || m_tlast !== (i == 7) || in_frame !== (i != 0)) begin
        errs++;
        $display("FAIL b2b_beat%0d got vld=%b dat=%h last=%b inf=%b exp vld=1 dat=%h last=%b inf=%b",
                 i, m_tvalid, m_tdata, m_tlast, in_frame, 64'(i), (i == 7), (i != 0));
      end
    end
    tot++; if (errs != 0) bad++;
    @(posedge clk); #1;
    @(negedge clk);
    tot++; if (m_tvalid !== 1'b0 || in_frame !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got vld=%b inf=%b exp 0 0", m_tvalid, in_frame); end
    tot++; if (stat_beat_count !== 8 || stat_pkt_count !== 1 || stat_err_count !== 0) begin
      bad++; $display("FAIL b2b_stats got beat=%0d pkt=%0d err=%0d exp 8 1 0", stat_beat_count, stat_pkt_count, stat_err_count); end
  endtask

  task automatic test_skid();
    int errs = 0;
    apply_reset();
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 64'h10; s_tlast = 1'b0; s_tuser = '0;
    @(posedge clk); #1 s_tdata = 64'h11;
    @(negedge clk);
    tot++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h10) begin
      bad++; $display("FAIL skid_first got vld=%b dat=%h exp 1 10", m_tvalid, m_tdata); end
    @(posedge clk); #1 s_tdata = 64'h12; s_tlast = 1'b1; m_tready = 1'b0;
    @(posedge clk); #1 s_tvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (m_tvalid !== 1'b1 || m_tdata !== 64'h11 || m_tlast !== 1'b0 || s_tready !== 1'b0) begin
        errs++;
        $display("FAIL skid_hold c=%0d got vld=%b dat=%h last=%b srdy=%b exp 1 11 0 0", c, m_tvalid, m_tdata, m_tlast, s_tready);
      end
    end
    tot++; if (errs != 0) bad++;
    @(posedge clk); #1 m_tready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tot++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h12 || m_tlast !== 1'b1 || s_tready !== 1'b1) begin
      bad++; $display("FAIL skid_drain got vld=%b dat=%h last=%b srdy=%b exp 1 12 1 1", m_tvalid, m_tdata, m_tlast, s_tready); end
    @(posedge clk); #1;
    @(negedge clk);
    tot++; if (obs_q.size() != 3 || obs_q[0][DW-1:0] !== 64'h10 || obs_q[1][DW-1:0] !== 64'h11 || obs_q[2][DW-1:0] !== 64'h12) begin
      bad++; $display("FAIL skid_order got n=%0d exp n=3 order 10,11,12", obs_q.size()); end
  endtask

  task automatic test_random();
    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] pd;
    logic [DW-1:0] d;
    logic pv, pr;
    bit drv_done, ok;
    int timeouts, stab_bad, sb_bad;
    exp_q.delete(); pd = '0; pv = 1'b0; pr = 1'b0;
    drv_done = 1'b0; timeouts = 0; stab_bad = 0; sb_bad = 0;
    apply_reset();
    fork
      begin
        for (int f = 0; f < 50; f++) begin
          for (int b = 0; b < 20; b++) begin
            d = {f[15:0], b[15:0], $urandom()};
            while ($urandom_range(1, 0) == 0) begin s_tvalid = 1'b0; @(posedge clk); #1; end
            send_beat(d, (b == 19), 1'b0, ok);
            if (!ok) timeouts++;
            exp_q.push_back({1'b0, (b == 19), d});
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(negedge clk);
          if (pv && !pr && (m_tvalid !== 1'b1 || {m_tuser, m_tlast, m_tdata} !== pd)) begin
            stab_bad++;
            $display("FAIL axi_stable got vld=%b dat=%h exp held dat=%h", m_tvalid, m_tdata, pd[DW-1:0]);
          end
          pv = m_tvalid; pr = m_tready; pd = {m_tuser, m_tlast, m_tdata};
          @(posedge clk); #1 m_tready = 1'($urandom_range(1, 0));
        end
      end
    join
    m_tready = 1'b1;
    for (int k = 0; k < 200 && obs_q.size() < 1000; k++) @(posedge clk);
    @(negedge clk);
    tot++; if (timeouts != 0) begin bad++; $display("FAIL rand_accept_timeouts got=%0d exp=0", timeouts); end
    tot++; if (stab_bad != 0) begin bad++; $display("FAIL rand_stability got=%0d violations exp=0", stab_bad); end
    tot++; if (obs_q.size() != 1000) begin bad++; $display("FAIL rand_count got=%0d exp=1000", obs_q.size()); end
    for (int i = 0; i < 1000 && i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) sb_bad++;
    tot++; if (sb_bad != 0) begin bad++; $display("FAIL rand_scoreboard got=%0d mismatching beats exp=0", sb_bad); end
    tot++; if (stat_pkt_count !== 50 || stat_beat_count !== 1000 || stat_err_count !== 0) begin
      bad++; $display("FAIL rand_stats got pkt=%0d beat=%0d err=%0d exp 50 1000 0", stat_pkt_count, stat_beat_count, stat_err_count); end
  endtask

  task automatic test_errors();
    bit ok, all_ok;
    all_ok = 1'b1;
    apply_reset();
    m_tready = 1'b1;
    send_beat(64'hA0, 1'b0, 1'b1, ok); all_ok &= ok;
    send_beat(64'hA1, 1'b1, 1'b0, ok); all_ok &= ok;
    send_beat(64'hB0, 1'b0, 1'b0, ok); all_ok &= ok;
    send_beat(64'hB1, 1'b0, 1'b0, ok); all_ok &= ok;
    send_beat(64'hB2, 1'b1, 1'b1, ok); all_ok &= ok;
    send_beat(64'hC0, 1'b1, 1'b0, ok); all_ok &= ok;
    tot++; if (!all_ok) begin bad++; $display("FAIL err_accept got=timeout exp=accepted"); end
    @(negedge clk);
    tot++; if (m_tvalid !== 1'b1 || m_tdata !== 64'hC0 || in_frame !== 1'b0) begin
      bad++; $display("FAIL err_single_pre got vld=%b dat=%h inf=%b exp 1 c0 0", m_tvalid, m_tdata, in_frame); end
    @(posedge clk); #1;
    @(negedge clk);
    tot++; if (in_frame !== 1'b0) begin bad++; $display("FAIL err_single_post got inf=%b exp=0", in_frame); end
    tot++; if (stat_err_count !== 1 || stat_pkt_count !== 3 || stat_beat_count !== 6) begin
      bad++; $display("FAIL err_stats got err=%0d pkt=%0d beat=%0d exp 1 3 6", stat_err_count, stat_pkt_count, stat_beat_count); end
  endtask

  task automatic test_wrap_and_reset();
    bit ok, all_ok;
    all_ok = 1'b1;
    apply_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 17; i++) begin send_beat(64'(i), 1'b1, 1'b0, ok); all_ok &= ok; end
    @(posedge clk); #1;
    @(negedge clk);
    tot++; if (!all_ok) begin bad++; $display("FAIL wrap_accept got=timeout exp=accepted"); end
    tot++; if (s4_pkt !== 4'd1 || s4_beat !== 4'd1) begin
      bad++; $display("FAIL wrap_cnt4 got pkt=%0d beat=%0d exp 1 1", s4_pkt, s4_beat); end
    tot++; if (stat_pkt_count !== 17) begin bad++; $display("FAIL wrap_cnt32 got pkt=%0d exp=17", stat_pkt_count); end
    // Open a frame, then stall the sink with OUT and SKID both occupied.
    @(posedge clk); #1;
    send_beat(64'h1F, 1'b0, 1'b0, ok);
    @(posedge clk); #1 m_tready = 1'b0;
    send_beat(64'h20, 1'b0, 1'b0, ok);
    send_beat(64'h21, 1'b0, 1'b0, ok);
    @(negedge clk);
    tot++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h20 || s_tready !== 1'b0 || in_frame !== 1'b1) begin
      bad++; $display("FAIL rst_pre got vld=%b dat=%h srdy=%b inf=%b exp 1 20 0 1", m_tvalid, m_tdata, s_tready, in_frame); end
    #2 rst_n = 1'b0;
    #1;
    tot++; if (m_tvalid !== 1'b0 || in_frame !== 1'b0 || s_tready !== 1'b0) begin
      bad++; $display("FAIL rst_async_ctl got vld=%b inf=%b srdy=%b exp 0 0 0", m_tvalid, in_frame, s_tready); end
    tot++; if (stat_pkt_count !== 0 || stat_err_count !== 0 || stat_beat_count !== 0 || s4_pkt !== 0 || s4_beat !== 0) begin
      bad++; $display("FAIL rst_async_cnt got pkt=%0d err=%0d beat=%0d pkt4=%0d beat4=%0d exp 0", stat_pkt_count, stat_err_count, stat_beat_count, s4_pkt, s4_beat); end
    obs_q.delete();
    m_tready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    tot++; if (obs_q.size() != 0 || m_tvalid !== 1'b0) begin
      bad++; $display("FAIL rst_no_stale got beats=%0d vld=%b exp 0 0", obs_q.size(), m_tvalid); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_skid();
    test_random();
    test_errors();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
